branch_predict: RTL and testbench
=================================

Name: branch_predict

Overview:
- Next-PC predictor in the fetch stage, directly downstream of the fetch-stage mini instruction decoder.
- Consumes the decoder's jal / jalr / B_type flags and its sign-extended immediate, together with the fetch PC.
- Produces the predicted next PC from a direct-mapped table of 2-bit saturating counters (BHT), trained by branch resolution from EX.
- Carries the prediction down the pipe in a registered sideband, so EX can detect mispredicts.

Parameters:
- IDX_W, 6, BHT index width; table holds 2^IDX_W entries of 2 bits each.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  IF/ID hold; freezes the registered sideband
- flush  input  1  IF/ID flush; clears the registered sideband
- pc_if  input  32  PC of the instruction currently in fetch
- jal  input  1  fetched instruction is JAL (from decoder)
- jalr  input  1  fetched instruction is JALR (from decoder)
- B_type  input  1  fetched instruction is a conditional branch (from decoder)
- imme  input  32  decoder immediate (J-type or B-type offset, bit0 = 0)
- upd_valid  input  1  EX resolved a conditional branch this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual branch outcome
- pred_taken  output  1  combinational: fetch redirects to pred_pc
- pred_pc  output  32  combinational: predicted next fetch PC
- pred_taken_id  output  1  registered pred_taken for the instruction in ID
- pred_pc_id  output  32  registered pred_pc for the instruction in ID

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - Every BHT entry = 2'b01 (weakly not-taken).
  - pred_taken_id = 0; pred_pc_id = 32'h0.
  - Combinational outputs during reset follow the table reset value, so a B_type fetch predicts not-taken.
- Indexing:
  - Read index = pc_if[IDX_W+1:2].
  - Update index = upd_pc[IDX_W+1:2].
  - No tags; aliasing is accepted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predicted taken = bit[1].
- Prediction (zero latency, purely combinational from pc_if, flags and the table):
  - jal -> pred_taken = 1, pred_pc = pc_if + imme.
  - B_type with counter bit[1] = 1 -> pred_taken = 1, pred_pc = pc_if + imme.
  - B_type with counter bit[1] = 0 -> pred_taken = 0, pred_pc = pc_if + 4.
  - jalr -> not predicted: pred_taken = 0, pred_pc = pc_if + 4. EX redirects.
  - Any other instruction -> pred_taken = 0, pred_pc = pc_if + 4.
  - If several flags are asserted (illegal), priority is jal > jalr > B_type.
- Arithmetic: 32-bit modulo addition, carry discarded. Example: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Training (on posedge clk when upd_valid = 1):
  - upd_taken = 1 -> counter increments, saturating at 11.
  - upd_taken = 0 -> counter decrements, saturating at 00.
  - upd_valid = 0 -> table unchanged.
  - Training is independent of stall and flush.
- Simultaneous read and update of the same index:
  - The combinational read returns the pre-update value (no bypass).
  - The new value is visible from the next cycle.
- Registered sideband, evaluated on posedge clk:
  - flush = 1 -> pred_taken_id <= 0, pred_pc_id <= 0. Flush has priority over stall.
  - else stall = 1 -> hold both registers.
  - else capture pred_taken and pred_pc.
- Reset mid-operation:
  - Asserting rst_n low immediately forces all counters and sideband registers to their reset values, irrespective of clk.
  - Any update in flight that cycle is lost.

Test Plan:
1. Reset, then pc_if=32'h0000_0100, B_type=1, imme=32'h10 -> pred_taken=0, pred_pc=32'h104. Next edge: pred_taken_id=0, pred_pc_id=32'h104.
2. Two upd_valid pulses with upd_pc=32'h100, upd_taken=1; then fetch as in test 1 -> pred_taken=1, pred_pc=32'h110. A third taken update keeps the counter at 11. Then one not-taken update -> still predicts taken (counter 10).
3. jal=1, pc_if=32'h0000_0200, imme=32'hFFFF_FFF0 -> pred_taken=1, pred_pc=32'h1F0. jalr=1 at the same PC -> pred_taken=0, pred_pc=32'h204.
4. Aliasing at IDX_W=6: training PC 32'h100 and fetching PC 32'h200 hit the same entry, so training 32'h100 taken ×2 makes 32'h200 (B_type) predict taken.
5. upd_valid for index k in the same cycle as a fetch at index k -> that cycle's output uses the old counter; the following cycle's output reflects the update.
6. Sideband: stall=1 for 3 cycles holds pred_pc_id while pc_if changes. flush and stall both high -> pred_taken_id=0, pred_pc_id=0. Asserting rst_n low mid-training -> a trained entry reads back 01.

Source files
------------

// File: rtl/branch_predict.sv
// Fetch-stage next-PC predictor: bimodal table of 2-bit saturating counters,
// trained from EX, with the prediction carried into ID through a registered sideband.
module branch_predict #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_if,
    input  logic        jal,
    input  logic        jalr,
    input  logic        B_type,
    input  logic [31:0] imme,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    output logic        pred_taken_id,
    output logic [31:0] pred_pc_id
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       bht_q [DEPTH];
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [1:0]       rd_cnt_s;
    logic [1:0]       upd_cnt_d;
    logic [31:0]      pc_seq_s;
    logic [31:0]      pc_tgt_s;
    logic             pred_taken_id_q;
    logic             pred_taken_id_d;
    logic [31:0]      pred_pc_id_q;
    logic [31:0]      pred_pc_id_d;
    logic             unused_upd_s;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    assign rd_idx_s     = pc_if[IDX_W+1:2];
    assign upd_idx_s    = upd_pc[IDX_W+1:2];
    assign rd_cnt_s     = bht_q[rd_idx_s];
    assign upd_cnt_d    = sat_step(bht_q[upd_idx_s], upd_taken);
    assign pc_seq_s     = pc_if + 32'd4;
    assign pc_tgt_s     = pc_if + imme;
    assign unused_upd_s = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Zero-latency prediction; jalr is left to EX, priority jal > jalr > B_type
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_seq_s;
        if (jal) begin
            pred_taken = 1'b1;
            pred_pc    = pc_tgt_s;
        end else if (jalr) begin
            pred_taken = 1'b0;
            pred_pc    = pc_seq_s;
        end else if (B_type && rd_cnt_s[1]) begin
            pred_taken = 1'b1;
            pred_pc    = pc_tgt_s;
        end else begin
            pred_taken = 1'b0;
            pred_pc    = pc_seq_s;
        end
    end

    // Counter table; read above sees the pre-update value (no bypass)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            bht_q[upd_idx_s] <= upd_cnt_d;
        end else begin
            bht_q[upd_idx_s] <= bht_q[upd_idx_s];
        end
    end

    // Sideband next state: flush wins over stall
    always_comb begin
        pred_taken_id_d = pred_taken_id_q;
        pred_pc_id_d    = pred_pc_id_q;
        if (flush) begin
            pred_taken_id_d = 1'b0;
            pred_pc_id_d    = 32'h0000_0000;
        end else if (stall) begin
            pred_taken_id_d = pred_taken_id_q;
            pred_pc_id_d    = pred_pc_id_q;
        end else begin
            pred_taken_id_d = pred_taken;
            pred_pc_id_d    = pred_pc;
        end
    end

    // Sideband registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_id_q <= 1'b0;
            pred_pc_id_q    <= 32'h0000_0000;
        end else begin
            pred_taken_id_q <= pred_taken_id_d;
            pred_pc_id_q    <= pred_pc_id_d;
        end
    end

    assign pred_taken_id = pred_taken_id_q;
    assign pred_pc_id    = pred_pc_id_q;

endmodule

// File: tb/tb_branch_predict.sv
// Self-checking bench for branch_predict: table-driven fetch vectors with a
// sideband scoreboard, plus hand-written training / stall / flush / reset sequences.
module tb_branch_predict;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] pc_if;
    logic        jal;
    logic        jalr;
    logic        B_type;
    logic [31:0] imme;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        pred_taken_id;
    logic [31:0] pred_pc_id;

    branch_predict #(.IDX_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pc_if         (pc_if),
        .jal           (jal),
        .jalr          (jalr),
        .B_type        (B_type),
        .imme          (imme),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .pred_taken_id (pred_taken_id),
        .pred_pc_id    (pred_pc_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        j;
        logic        jr;
        logic        b;
        logic [31:0] imm;
        logic        exp_t;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        t;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs [9];
    sb_t  exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic j, input logic jr,
                         input logic b, input logic [31:0] imm);
        pc_if  = pc;
        jal    = j;
        jalr   = jr;
        B_type = b;
        imme   = imm;
    endtask

    task automatic pop_check(input string name);
        sb_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, pred_pc_id);
        end else begin
            e = exp_q.pop_front();
            check({name, ".taken_id"}, {31'd0, pred_taken_id}, {31'd0, e.t});
            check({name, ".pc_id"}, pred_pc_id, e.pc);
        end
    endtask

    // Drive a fetch, check the combinational prediction, then the sideband after the edge.
    task automatic step(input string name, input logic [31:0] pc, input logic j, input logic jr,
                        input logic b, input logic [31:0] imm,
                        input logic exp_t, input logic [31:0] exp_pc);
        sb_t e;
        fetch(pc, j, jr, b, imm);
        #2;
        check({name, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        check({name, ".pc"}, pred_pc, exp_pc);
        e.t  = exp_t;
        e.pc = exp_pc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        sb_t e;
        vecs[0] = '{32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0104};
        vecs[1] = '{32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 1'b1, 32'h0000_01F0};
        vecs[2] = '{32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h0000_0204};
        vecs[3] = '{32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0304};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0010};
        vecs[6] = '{32'h0000_0400, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0408};
        vecs[7] = '{32'h0000_0400, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0404};
        vecs[8] = '{32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0000_07FC, 1'b1, 32'h0000_17FC};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        fetch(32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        #3;
        check("rst.taken", {31'd0, pred_taken}, 32'd0);
        check("rst.pc", pred_pc, 32'h0000_0104);
        check("rst.taken_id", {31'd0, pred_taken_id}, 32'd0);
        check("rst.pc_id", pred_pc_id, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Untrained table: fixed-expectation vectors
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), vecs[i].pc, vecs[i].j, vecs[i].jr, vecs[i].b,
                 vecs[i].imm, vecs[i].exp_t, vecs[i].exp_pc);
        end

        // Training up, saturation at 11, then back down
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b1);
        step("trn11", 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0110);
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b0);
        step("trn10", 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0110);
        train(32'h0000_0100, 1'b0);
        step("trn01", 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0104);

        // Aliasing 0x100 / 0x200, then saturation at 00
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b1);
        step("alias", 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0210);
        for (int i = 0; i < 4; i++) train(32'h0000_0100, 1'b0);
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b1);
        step("sat00", 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0210);

        // Same-cycle read and update of entry 0 (counter 10 -> 01)
        fetch(32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b0;
        #2;
        check("rw.old_taken", {31'd0, pred_taken}, 32'd1);
        check("rw.old_pc", pred_pc, 32'h0000_0110);
        e.t = 1'b1; e.pc = 32'h0000_0110;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        check("rw.new_taken", {31'd0, pred_taken}, 32'd0);
        check("rw.new_pc", pred_pc, 32'h0000_0104);
        pop_check("rw");

        // Stall holds the sideband while fetch moves on
        step("pre_stall", 32'h0000_0500, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0600);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0000_0700 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d.taken_id", i), {31'd0, pred_taken_id}, 32'd1);
            check($sformatf("stall%0d.pc_id", i), pred_pc_id, 32'h0000_0600);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush.taken_id", {31'd0, pred_taken_id}, 32'd0);
        check("flush.pc_id", pred_pc_id, 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Reset in the middle of training returns the entry to 01
        train(32'h0000_0100, 1'b1);
        train(32'h0000_0100, 1'b1);
        step("pre_rst", 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0110);
        upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_taken = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.taken", {31'd0, pred_taken}, 32'd0);
        check("midrst.pc", pred_pc, 32'h0000_0104);
        check("midrst.taken_id", {31'd0, pred_taken_id}, 32'd0);
        check("midrst.pc_id", pred_pc_id, 32'h0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst.taken", {31'd0, pred_taken}, 32'd0);
        train(32'h0000_0100, 1'b1);
        step("postrst10", 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
